gate_truth_table_ctrl: RTL and testbench

Synthesizable sequencer that exercises a 2-input combinational gate (default target: nand_gate) through all 4 input vectors. It captures the gate's responses into a 4-bit truth table and compares it against an expected pattern. It replaces hand-written stimulus with an on-chip self-test that a top level or bench triggers with a start pulse.

---
 rtl/gtc_pkg.sv | 17 +
 rtl/gate_truth_table_ctrl_if.sv | 47 ++++
 rtl/gtc_settle_timer.sv | 35 +++
 rtl/gate_truth_table_ctrl.sv | 122 ++++++++++++
 tb/tb_gate_truth_table_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gtc_pkg.sv
// Shared types and constants for the gate truth-table self-test sequencer.
package gtc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gtc_state_e;

  localparam int         NUM_VECTORS = 4;
  localparam logic [3:0] NAND_TT     = 4'b0111;

  typedef logic [1:0] vec_idx_t;

  localparam vec_idx_t LAST_VEC = vec_idx_t'(NUM_VECTORS - 1);

endpackage

// File: rtl/gate_truth_table_ctrl_if.sv
// Control/result bundle between the truth-table sequencer and its environment.
// err_count exists only when GTC_ERR_COUNT_EN is defined.
interface gate_truth_table_ctrl_if;
  logic       start;
  logic       gate_in1;
  logic       gate_in2;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] truth_table;
  logic [3:0] err_mask;
`ifdef GTC_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  modport slave (
    input  start,
    input  gate_out,
    output gate_in1,
    output gate_in2,
    output busy,
    output done,
    output pass,
    output truth_table,
    output err_mask
`ifdef GTC_ERR_COUNT_EN
    , output err_count
`endif
  );

  modport master (
    output start,
    output gate_out,
    input  gate_in1,
    input  gate_in2,
    input  busy,
    input  done,
    input  pass,
    input  truth_table,
    input  err_mask
`ifdef GTC_ERR_COUNT_EN
    , input err_count
`endif
  );

endinterface

// File: rtl/gtc_settle_timer.sv
// Loadable down-counter that sets how long each vector is held before sampling.
module gtc_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_table_ctrl.sv
// Walks a 2-input gate through all four input vectors and grades its truth table.
// Define GTC_ERR_COUNT_EN to add a saturating count of failed runs (err_count).
//
// state | meaning
// IDLE  | results held, waiting for start
// RUN   | driving vectors, sampling gate_out once the settle timer expires
// DONE  | one cycle: grade table, pulse done, release gate inputs
module gate_truth_table_ctrl
  import gtc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED_TT   = NAND_TT,
  parameter int unsigned SETTLE_W      = 4
) (
  input logic                     clk,
  input logic                     rst,
  gate_truth_table_ctrl_if.slave  bus
);

  gtc_state_e state_q;
  vec_idx_t   vec_q;
  vec_idx_t   vec_d;
  logic       gate_in1_q;
  logic       gate_in2_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] tt_q;
  logic [3:0] err_q;
  logic       tmr_zero;
  logic       tmr_load;
  logic       tmr_en;
`ifdef GTC_ERR_COUNT_EN
  logic [7:0] err_cnt_q;
`endif

  assign vec_d    = vec_idx_t'(vec_q + 2'd1);
  assign tmr_en   = (state_q == RUN);
  // Reload on acceptance and whenever a non-final vector has just been sampled.
  assign tmr_load = ((state_q == IDLE) && bus.start) ||
                    ((state_q == RUN) && tmr_zero && (vec_q != LAST_VEC));

  gtc_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_W'(SETTLE_CYCLES)),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      gate_in1_q <= 1'b0;
      gate_in2_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tt_q       <= '0;
      err_q      <= '0;
`ifdef GTC_ERR_COUNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q                  <= RUN;
            vec_q                    <= '0;
            {gate_in1_q, gate_in2_q} <= 2'b00;
            busy_q                   <= 1'b1;
            tt_q                     <= '0;
            err_q                    <= '0;
            pass_q                   <= 1'b0;
          end
        end
        RUN: begin
          if (tmr_zero) begin
            tt_q[vec_q] <= bus.gate_out;
            if (vec_q == LAST_VEC) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              vec_q                    <= vec_d;
              {gate_in1_q, gate_in2_q} <= vec_d;
            end
          end
        end
        DONE: begin
          state_q                  <= IDLE;
          done_q                   <= 1'b1;
          err_q                    <= tt_q ^ EXPECTED_TT;
          pass_q                   <= (tt_q == EXPECTED_TT);
          {gate_in1_q, gate_in2_q} <= 2'b00;
`ifdef GTC_ERR_COUNT_EN
          if ((tt_q != EXPECTED_TT) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gate_in1    = gate_in1_q;
  assign bus.gate_in2    = gate_in2_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.truth_table = tt_q;
  assign bus.err_mask    = err_q;
`ifdef GTC_ERR_COUNT_EN
  assign bus.err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_ctrl.sv
// Randomised self-checking bench: two sequencers (settle 2 and settle 0) share stimulus
// and are compared every cycle against a run-offset model of the expected outputs.
module tb_gate_truth_table_ctrl;

  localparam int         P_A    = 3;  // cycles per vector, SETTLE_CYCLES=2
  localparam int         P_B    = 1;  // cycles per vector, SETTLE_CYCLES=0
  localparam logic [3:0] EXP_TT = 4'b0111;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [3:0] lut   = 4'b0111;
  int         total = 0;
  int         bad   = 0;
  bit         chk_en = 1'b0;

  // Model: k = cycles since the accepting edge, -1 when idle.
  int         k[2]     = '{-1, -1};
  logic [3:0] m_tt[2]  = '{4'h0, 4'h0};
  logic [3:0] m_err[2] = '{4'h0, 4'h0};
  logic       m_pass[2] = '{1'b0, 1'b0};
  int         m_cnt[2] = '{0, 0};

  always #5 clk = ~clk;

  gate_truth_table_ctrl_if if_a ();
  gate_truth_table_ctrl_if if_b ();

  gate_truth_table_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  gate_truth_table_ctrl #(
    .SETTLE_CYCLES (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  assign if_a.start    = start;
  assign if_b.start    = start;
  assign if_a.gate_out = lut[{if_a.gate_in1, if_a.gate_in2}];
  assign if_b.gate_out = lut[{if_b.gate_in1, if_b.gate_in2}];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_vec(input int kk, input int p);
    if (kk < 0 || kk > 4 * p) return 0;
    if (kk / p > 3) return 3;
    return kk / p;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p;
      p = (i == 0) ? P_A : P_B;
      if (rst) begin
        k[i] = -1; m_tt[i] = 4'h0; m_err[i] = 4'h0; m_pass[i] = 1'b0; m_cnt[i] = 0;
      end else if (k[i] < 0 || k[i] == 4 * p + 1) begin
        if (start) begin
          k[i] = 0; m_tt[i] = 4'h0; m_err[i] = 4'h0; m_pass[i] = 1'b0;
        end else begin
          k[i] = -1;
        end
      end else begin
        k[i]++;
        if ((k[i] % p == 0) && (k[i] <= 4 * p))
          m_tt[i][k[i] / p - 1] = lut[k[i] / p - 1];
        if (k[i] == 4 * p + 1) begin
          m_pass[i] = (m_tt[i] == EXP_TT);
          m_err[i]  = m_tt[i] ^ EXP_TT;
          if (!m_pass[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
      end
    end
  end

  task automatic chk_inst(input string nm, input int i, input int p,
                          input logic busy, done, g1, g2,
                          input logic [3:0] tt, err, input logic ps);
    int v;
    v = exp_vec(k[i], p);
    chk({nm, ".busy"}, int'(busy), int'(k[i] >= 0 && k[i] < 4 * p));
    chk({nm, ".done"}, int'(done), int'(k[i] == 4 * p + 1));
    chk({nm, ".gate_in1"}, int'(g1), (v >> 1) & 1);
    chk({nm, ".gate_in2"}, int'(g2), v & 1);
    chk({nm, ".truth_table"}, int'(tt), int'(m_tt[i]));
    chk({nm, ".err_mask"}, int'(err), int'(m_err[i]));
    chk({nm, ".pass"}, int'(ps), int'(m_pass[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_inst("a", 0, P_A, if_a.busy, if_a.done, if_a.gate_in1, if_a.gate_in2,
               if_a.truth_table, if_a.err_mask, if_a.pass);
      chk_inst("b", 1, P_B, if_b.busy, if_b.done, if_b.gate_in1, if_b.gate_in2,
               if_b.truth_table, if_b.err_mask, if_b.pass);
`ifdef GTC_ERR_COUNT_EN
      chk("a.err_count", int'(if_a.err_count), m_cnt[0]);
      chk("b.err_count", int'(if_b.err_count), m_cnt[1]);
`endif
    end
  end

  // Pulse start, then return at the negedge where dut_a shows done (or after a bound).
  task automatic run_measure(output int lat_a, output int lat_b, output int ba, output int bb);
    lat_a = -1; lat_b = -1; ba = 0; bb = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (if_a.busy) ba++;
      if (if_b.busy) bb++;
      if (if_b.done && lat_b < 0) lat_b = c;
      if (if_a.done) begin
        lat_a = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int la, lb, ba, bb, nd, fd, d1, d2;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst.a_outs", int'({if_a.busy, if_a.done, if_a.gate_in1, if_a.gate_in2, if_a.pass,
                            if_a.truth_table, if_a.err_mask}), 0);
    chk("rst.b_outs", int'({if_b.busy, if_b.done, if_b.gate_in1, if_b.gate_in2, if_b.pass,
                            if_b.truth_table, if_b.err_mask}), 0);
    rst = 1'b0;

    lut = EXP_TT;
    run_measure(la, lb, ba, bb);
    chk("nand.lat_a", la, 13);
    chk("nand.lat_b", lb, 5);
    chk("nand.busy_cycles_a", ba, 12);
    chk("nand.busy_cycles_b", bb, 4);
    chk("nand.tt_a", int'(if_a.truth_table), 7);
    chk("nand.err_a", int'(if_a.err_mask), 0);
    chk("nand.pass_a", int'(if_a.pass), 1);
    chk("nand.tt_b", int'(if_b.truth_table), 7);
    chk("model.nand_tt", int'(m_tt[0]), 7);
    chk("model.nand_pass", int'(m_pass[0]), 1);

    lut = 4'b1000;
    run_measure(la, lb, ba, bb);
    chk("and.lat_a", la, 13);
    chk("and.tt_a", int'(if_a.truth_table), 8);
    chk("and.err_a", int'(if_a.err_mask), 15);
    chk("and.pass_a", int'(if_a.pass), 0);
    chk("model.and_err", int'(m_err[0]), 15);
`ifdef GTC_ERR_COUNT_EN
    chk("and.err_count_a1", int'(if_a.err_count), 1);
`endif
    run_measure(la, lb, ba, bb);
`ifdef GTC_ERR_COUNT_EN
    chk("and.err_count_a2", int'(if_a.err_count), 2);
    chk("and.err_count_b2", int'(if_b.err_count), 2);
`endif

    lut = EXP_TT;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0; fd = -1;
    for (int c = 0; c < 25; c++) begin
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (if_a.done) begin
        nd++;
        if (fd < 0) fd = c;
      end
      @(negedge clk);
    end
    chk("ignore.done_count", nd, 1);
    chk("ignore.done_at", fd, 13);
    chk("ignore.tt_a", int'(if_a.truth_table), 7);
    chk("ignore.pass_a", int'(if_a.pass), 1);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      if (if_a.done) nd++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    if (if_a.done) nd++;
    chk("abort.no_done", nd, 0);
    chk("abort.a_outs", int'({if_a.busy, if_a.done, if_a.gate_in1, if_a.gate_in2, if_a.pass,
                              if_a.truth_table, if_a.err_mask}), 0);
    rst = 1'b0;
    run_measure(la, lb, ba, bb);
    chk("abort.fresh_lat_a", la, 13);
    chk("abort.fresh_tt_a", int'(if_a.truth_table), 7);

    @(negedge clk); start = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 14) begin
        chk("hold.cleared_tt_a", int'(if_a.truth_table), 0);
        chk("hold.cleared_pass_a", int'(if_a.pass), 0);
      end
      if (if_a.done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    start = 1'b0;
    chk("hold.done1", d1, 13);
    chk("hold.done2", d2, 27);
    repeat (20) @(negedge clk);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0)
        lut = ($urandom_range(0, 1) == 0) ? EXP_TT : 4'($urandom_range(0, 15));
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
